keypad_scan: RTL and testbench
==============================

Name: keypad_scan

Overview:
- 4x4 matrix keypad scanner: the input-side counterpart to the 7-segment digit scan driver.
- Drives columns low one at a time, samples rows, debounces, and emits one key code per press.
- Feeds the clock's time-set / edit-select control logic; shares the panel's slow-scan timing style.

Parameters:
- SCAN_DIV_W, 16: scan tick every 2^SCAN_DIV_W clocks; one column step per tick (~763 Hz at 50 MHz).
- DEBOUNCE_TICKS, 4: consecutive identical tick samples required to accept a press or a release (>=2).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- col_out  out  4  column drive, active-low, exactly one bit low at all times
- row_in  in  4  row sense, active-low (pulled up externally), asynchronous
- key_code  out  4  code of the accepted key = {row[1:0], col[1:0]}; held until the next accepted press
- key_valid  out  1  one-clk pulse when a press is accepted
- key_held  out  1  high from acceptance until the release is debounced

Behaviour:
- Synchroniser: row_in passes through 2 flops (row_s) before any use.
- Prescaler: free-running SCAN_DIV_W-bit counter; tick = counter all-ones. Sampling and column changes happen only on tick, so each column drive is stable for a full period before it is sampled.
- Row priority: if several rows of row_s are low, the lowest row index wins.
- FSM states: SCAN, DEBOUNCE, HELD.
- SCAN, on tick:
  - Any row_s bit low: latch cand_row (priority encoded) and cand_col = current column; deb_cnt <= 1; go DEBOUNCE; column frozen.
  - No row low: column advances 0->1->2->3->0. col_out = ~(1 << col).
- DEBOUNCE, on tick:
  - row_s[cand_row] still low: deb_cnt++.
  - deb_cnt reaches DEBOUNCE_TICKS on that tick: key_code <= {cand_row, cand_col}; key_valid = 1 for exactly one clk; key_held <= 1; go HELD; rel_cnt <= 0.
  - row_s[cand_row] high: abandon the candidate, advance the column, go SCAN. No pulse.
- HELD, on tick (column stays frozen):
  - row_s[cand_row] high: rel_cnt++.
  - row_s[cand_row] low: rel_cnt <= 0.
  - rel_cnt reaches DEBOUNCE_TICKS: key_held <= 0, advance the column, go SCAN.
  - Other keys pressed during HELD are ignored, with no rollover.
- Latency: press-to-pulse is at most 2 sync clks + (4 + DEBOUNCE_TICKS) ticks.
- Reset values: col_out = 4'b1110, key_code = 0, key_valid = 0, key_held = 0, state SCAN, all counters 0.
- Reset mid-operation: returns to the reset values on the next edge. No pulse from a pending candidate.
- Simultaneous tick and reset: reset wins.
- deb_cnt and rel_cnt saturate; they never wrap.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined (auto-repeat):
  - Adds parameters REPEAT_DELAY (default 300 ticks) and REPEAT_PERIOD (default 80 ticks).
  - In HELD with the key still low, a hold counter runs. First extra key_valid pulse fires after REPEAT_DELAY ticks, then one every REPEAT_PERIOD ticks. key_code is unchanged.
  - Any release sample (rel_cnt > 0) resets the hold counter.
- Undefined: exactly one key_valid pulse per press; no repeat logic is synthesised.

Decomposition:
- Package keypad_pkg:
  - state enum (SCAN, DEBOUNCE, HELD)
  - NUM_ROWS = 4, NUM_COLS = 4
  - key_code_t (4-bit)
  - named codes for function keys: KEY_SET = 4'hA, KEY_NEXT = 4'hB, KEY_UP = 4'hC, KEY_DOWN = 4'hD
- Sub-module: sync_2ff (parameterised width), used for row_in. Everything else stays in keypad_scan.

Test Plan:
- Bench parameters: SCAN_DIV_W = 2 (tick every 4 clks), DEBOUNCE_TICKS = 3.
- Keypad model: row r is low only while col_out[c] = 0 and key (r,c) is pressed.
- Reset: assert rst for 2 clks -> col_out = 4'b1110, key_code = 0, key_valid = 0, key_held = 0. No keys pressed -> col_out steps 1110->1101->1011->0111->1110, each held 4 clks.
- Clean press of key (row2, col1) -> col_out freezes at 4'b1101; exactly one key_valid pulse; key_code = 4'h9; key_held = 1. Hold for 20 ticks -> no further pulse (macro undefined).
- Bounce on press: key (1,3) low for 1 tick then high -> no key_valid; scan resumes at col 0 (col_out = 4'b1110 next tick).
- Release bounce: while key 9 is held, row high for 2 ticks, low for 1, then high for 3 -> key_held stays 1 until the third consecutive high tick, then 0; no second pulse; scanning resumes.
- Multi-key: keys (1,0) and (3,0) pressed together -> key_code = 4'h4. Reset pulsed during DEBOUNCE -> no key_valid; col_out = 4'b1110 the next clk.
- KEYPAD_REPEAT_EN defined with REPEAT_DELAY = 5, REPEAT_PERIOD = 2, key 4'hC held 12 ticks -> pulses at acceptance, +5, +7, +9, +11 ticks, all with code 4'hC.

Source files
------------

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, sizes and helpers for the 4x4 keypad scanner
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } state_t;

    typedef logic [3:0] key_code_t;

    // Function keys consumed by the time-set / edit-select logic
    localparam key_code_t KEY_SET  = 4'hA;
    localparam key_code_t KEY_NEXT = 4'hB;
    localparam key_code_t KEY_UP   = 4'hC;
    localparam key_code_t KEY_DOWN = 4'hD;

    // Lowest-indexed low row wins when several rows are active
    function automatic logic [1:0] row_prio(input logic [NUM_ROWS-1:0] rows);
        row_prio = 2'd3;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (!rows[i]) begin
                row_prio = 2'(i);
            end
        end
    endfunction

    function automatic logic [NUM_COLS-1:0] col_drive(input logic [1:0] col);
        col_drive = ~(4'b0001 << col);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for asynchronous level inputs
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 matrix keypad scanner with debounce; KEYPAD_REPEAT_EN adds auto-repeat
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV_W     = 16,
    parameter int DEBOUNCE_TICKS = 4
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter int REPEAT_DELAY   = 300,
    parameter int REPEAT_PERIOD  = 80
`endif
) (
    input  logic                clk,
    input  logic                rst,
    output logic [NUM_COLS-1:0] col_out,
    input  logic [NUM_ROWS-1:0] row_in,
    output key_code_t           key_code,
    output logic                key_valid,
    output logic                key_held
);

    localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_TICKS);

    logic [NUM_ROWS-1:0]   row_s;
    logic [SCAN_DIV_W-1:0] div_cnt;
    logic                  tick;
    state_t                state;
    logic [1:0]            col;
    logic [1:0]            col_inc;
    logic [1:0]            cand_row;
    logic [1:0]            cand_col;
    logic [CNT_W-1:0]      deb_cnt;
    logic [CNT_W-1:0]      rel_cnt;
    logic [CNT_W-1:0]      deb_nxt;
    logic [CNT_W-1:0]      rel_nxt;
    logic                  any_low;
    logic                  cand_low;

    sync_2ff #(
        .WIDTH     (NUM_ROWS),
        .RESET_VAL ({NUM_ROWS{1'b1}})
    ) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d   (row_in),
        .q   (row_s)
    );

`ifdef KEYPAD_REPEAT_EN
    logic [15:0] rep_cnt;
    logic [15:0] rep_nxt;
    logic [15:0] rep_target;
    logic        rep_first;

    always_comb begin
        rep_nxt    = rep_cnt + 16'd1;
        rep_target = rep_first ? 16'(REPEAT_DELAY) : 16'(REPEAT_PERIOD);
    end
`endif

    always_comb begin
        tick     = &div_cnt;
        any_low  = ~&row_s;
        cand_low = ~row_s[cand_row];
        col_inc  = col + 2'd1;
        deb_nxt  = (deb_cnt == DEB_MAX) ? deb_cnt : deb_cnt + 1'b1;
        rel_nxt  = (rel_cnt == DEB_MAX) ? rel_cnt : rel_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            state     <= SCAN;
            col       <= 2'd0;
            col_out   <= 4'b1110;
            cand_row  <= 2'd0;
            cand_col  <= 2'd0;
            deb_cnt   <= '0;
            rel_cnt   <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= '0;
            rep_first <= 1'b1;
`endif
        end else begin
            div_cnt   <= div_cnt + 1'b1;
            key_valid <= 1'b0;
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (any_low) begin
                            cand_row <= row_prio(row_s);
                            cand_col <= col;
                            deb_cnt  <= CNT_W'(1);
                            state    <= DEBOUNCE;
                        end else begin
                            col     <= col_inc;
                            col_out <= col_drive(col_inc);
                        end
                    end
                    DEBOUNCE: begin
                        if (cand_low) begin
                            deb_cnt <= deb_nxt;
                            if (deb_nxt == DEB_MAX) begin
                                key_code  <= {cand_row, cand_col};
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                rel_cnt   <= '0;
                                state     <= HELD;
`ifdef KEYPAD_REPEAT_EN
                                rep_cnt   <= '0;
                                rep_first <= 1'b1;
`endif
                            end
                        end else begin
                            col     <= col_inc;
                            col_out <= col_drive(col_inc);
                            state   <= SCAN;
                        end
                    end
                    HELD: begin
                        // Column stays frozen so only the accepted key is watched
                        if (cand_low) begin
                            rel_cnt <= '0;
`ifdef KEYPAD_REPEAT_EN
                            if (rep_nxt == rep_target) begin
                                key_valid <= 1'b1;
                                rep_cnt   <= '0;
                                rep_first <= 1'b0;
                            end else begin
                                rep_cnt <= rep_nxt;
                            end
`endif
                        end else begin
                            rel_cnt <= rel_nxt;
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt   <= '0;
                            rep_first <= 1'b1;
`endif
                            if (rel_nxt == DEB_MAX) begin
                                key_held <= 1'b0;
                                col      <= col_inc;
                                col_out  <= col_drive(col_inc);
                                state    <= SCAN;
                            end
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - directed self-checking bench for keypad_scan
module tb_keypad_scan;

    logic       clk;
    logic       rst;
    logic [3:0] col_out;
    logic [3:0] row_in;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [3:0] keys [4];
    int         checks = 0;
    int         errors = 0;
    int         pulse_cnt = 0;
    int         base;

    keypad_scan #(
        .SCAN_DIV_W     (2),
        .DEBOUNCE_TICKS (3)
`ifdef KEYPAD_REPEAT_EN
        ,
        .REPEAT_DELAY   (5),
        .REPEAT_PERIOD  (2)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .col_out   (col_out),
        .row_in    (row_in),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Row r reads low only while a pressed key in that row sits on the driven column
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (|(keys[r] & ~col_out)) begin
                row_in[r] = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (key_valid === 1'b1) begin
            pulse_cnt <= pulse_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (4 * n) @(negedge clk);
    endtask

    task automatic clear_keys();
        for (int r = 0; r < 4; r++) begin
            keys[r] = 4'b0000;
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_keys();
        repeat (2) @(negedge clk);
        check("rst_col_out", 32'(col_out), 'hE);
        check("rst_key_code", 32'(key_code), 'h0);
        check("rst_key_valid", 32'(key_valid), 'h0);
        check("rst_key_held", 32'(key_held), 'h0);
        rst = 1'b0;

        // Idle scan: each column held for 4 clocks
        repeat (3) @(negedge clk);
        check("scan_col0_hold", 32'(col_out), 'hE);
        @(negedge clk);
        check("scan_col1", 32'(col_out), 'hD);
        tick(1);
        check("scan_col2", 32'(col_out), 'hB);
        tick(1);
        check("scan_col3", 32'(col_out), 'h7);
        tick(1);
        check("scan_wrap", 32'(col_out), 'hE);

        // Clean press of key (2,1)
        keys[2] = 4'b0010;
        base = pulse_cnt;
        tick(3);
        check("press_frozen_col", 32'(col_out), 'hD);
        check("press_no_early_pulse", 32'(key_valid), 'h0);
        tick(1);
        check("press_valid", 32'(key_valid), 'h1);
        check("press_code", 32'(key_code), 'h9);
        check("press_held", 32'(key_held), 'h1);
        tick(20);
`ifdef KEYPAD_REPEAT_EN
        check("hold20_pulses", 32'(pulse_cnt - base), 9);
`else
        check("hold20_pulses", 32'(pulse_cnt - base), 1);
`endif
        check("hold20_held", 32'(key_held), 'h1);
        check("hold20_col", 32'(col_out), 'hD);

        // Release bounce: high 2, low 1, high 3
        base = pulse_cnt;
        keys[2] = 4'b0000;
        tick(2);
        check("relb_held_a", 32'(key_held), 'h1);
        keys[2] = 4'b0010;
        tick(1);
        keys[2] = 4'b0000;
        tick(2);
        check("relb_held_b", 32'(key_held), 'h1);
        tick(1);
        check("relb_released", 32'(key_held), 'h0);
        check("relb_col_resume", 32'(col_out), 'hB);
        check("relb_no_pulse", 32'(pulse_cnt - base), 0);

        // Press bounce on key (1,3)
        base = pulse_cnt;
        keys[1] = 4'b1000;
        tick(2);
        check("pb_col3", 32'(col_out), 'h7);
        keys[1] = 4'b0000;
        tick(1);
        check("pb_resume_col0", 32'(col_out), 'hE);
        check("pb_no_pulse", 32'(pulse_cnt - base), 0);

        // Multi-key on column 0: row 1 beats row 3
        base = pulse_cnt;
        keys[1] = 4'b0001;
        keys[3] = 4'b0001;
        tick(3);
        check("multi_valid", 32'(key_valid), 'h1);
        check("multi_code", 32'(key_code), 'h4);
        clear_keys();
        tick(3);
        check("multi_released", 32'(key_held), 'h0);
        check("multi_col_resume", 32'(col_out), 'hD);
        check("multi_one_pulse", 32'(pulse_cnt - base), 1);

        // Reset while debouncing key (0,1)
        keys[0] = 4'b0010;
        tick(1);
        check("mid_debounce_no_valid", 32'(key_valid), 'h0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_col_out", 32'(col_out), 'hE);
        check("mid_rst_key_code", 32'(key_code), 'h0);
        check("mid_rst_key_valid", 32'(key_valid), 'h0);
        check("mid_rst_key_held", 32'(key_held), 'h0);
        clear_keys();
        rst = 1'b0;
        base = pulse_cnt;
        tick(1);
        check("mid_rst_scan_col1", 32'(col_out), 'hD);
        tick(5);
        check("mid_rst_no_pulse", 32'(pulse_cnt - base), 0);

        // Key C (3,0) held 12 ticks after acceptance
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        keys[3] = 4'b0001;
        base = pulse_cnt;
        tick(3);
        check("keyc_valid", 32'(key_valid), 'h1);
        check("keyc_code", 32'(key_code), 'hC);
`ifdef KEYPAD_REPEAT_EN
        tick(4);
        check("rep_plus4_quiet", 32'(key_valid), 'h0);
        tick(1);
        check("rep_plus5", 32'(key_valid), 'h1);
        tick(1);
        check("rep_plus6_quiet", 32'(key_valid), 'h0);
        tick(1);
        check("rep_plus7", 32'(key_valid), 'h1);
        tick(2);
        check("rep_plus9", 32'(key_valid), 'h1);
        tick(2);
        check("rep_plus11", 32'(key_valid), 'h1);
        check("rep_code", 32'(key_code), 'hC);
        tick(1);
        clear_keys();
        tick(3);
        check("rep_total", 32'(pulse_cnt - base), 5);
`else
        tick(5);
        check("norep_plus5_quiet", 32'(key_valid), 'h0);
        tick(7);
        clear_keys();
        tick(3);
        check("norep_total", 32'(pulse_cnt - base), 1);
`endif
        check("keyc_released", 32'(key_held), 'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
